coord_stepper: RTL



---
 rtl/coord_stepper.sv | 100 ++++++++++
 1 files changed

// File: rtl/coord_stepper.sv
// Sequential controller that drives a +/-5 ALU and commits one step per command.
// Holds the (X, Y) coordinate pair, a saturating move counter and a done/rejected response pulse.
module coord_stepper #(
    parameter int size      = 5,
    parameter int MAX_COORD = 31,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_dir,
    output logic             cmd_ready,
    output logic [size-1:0]  alu_in1,
    output logic [size-1:0]  alu_in2,
    output logic             alu_op,
    output logic             alu_iseq,
    input  logic [size:0]    alu_res,
    input  logic             alu_sign,
    output logic [size-1:0]  x,
    output logic [size-1:0]  y,
    output logic             done,
    output logic             rejected,
    output logic [CNT_W-1:0] move_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  dir_q;
    logic [size:0] res_mag;
    logic        legal;
    logic        unused_res_msb;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on state, and cmd_valid/cmd_dir are ignored otherwise.
    assign cmd_ready = (state == IDLE);

    assign alu_in1  = x;
    assign alu_in2  = y;
    assign alu_op   = dir_q[0];
    assign alu_iseq = dir_q[1];

    // The ALU's sign output is the authority on wrap/overflow; its copy in alu_res is not used.
    assign unused_res_msb = alu_res[size];
    assign res_mag        = {1'b0, alu_res[size-1:0]};
    assign legal          = !alu_sign && (res_mag <= (size+1)'(MAX_COORD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dir_q      <= 2'b00;
            x          <= size'(INIT_X);
            y          <= size'(INIT_Y);
            done       <= 1'b0;
            rejected   <= 1'b0;
            move_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    rejected <= 1'b0;
                    if (cmd_valid) begin
                        dir_q <= cmd_dir;
                        state <= CALC;
                    end
                end
                CALC: begin
                    done     <= 1'b1;
                    rejected <= !legal;
                    if (legal) begin
                        if (dir_q[1]) begin
                            y <= alu_res[size-1:0];
                        end else begin
                            x <= alu_res[size-1:0];
                        end
                        if (move_count != {CNT_W{1'b1}}) begin
                            move_count <= move_count + CNT_W'(1);
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    done     <= 1'b0;
                    rejected <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    done     <= 1'b0;
                    rejected <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
